// File: rtl/sst_pkg.sv
// sst_pkg: shared types and constants for the mapper save-state (SST) sequencer.
//   sst_state_t : sequencer state encoding (exposed as sst_seq.state for debug).
//   sst_bus_t   : SST master bundle (act, addr, we_reg, dato), the same fields as
//                 the existing SSTBus.
//   SST_MAP_IDX_ADDR : SST address holding the mapper index byte.
//   M2_TIMEOUT  : number of clk cycles to wait for an m2 edge before giving up.
package sst_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ARM    = 4'd1,
      ST_S_RD   = 4'd2,
      ST_S_WR   = 4'd3,
      ST_L_RD   = 4'd4,
      ST_L_WR   = 4'd5,
      ST_L_HOLD = 4'd6,
      ST_NEXT   = 4'd7,
      ST_FIN    = 4'd8,
      ST_C_RD   = 4'd9,   // map check: fetch buffered mapper index
      ST_C_CMP  = 4'd10   // map check: compare with live mapper index
   } sst_state_t;

   localparam logic [7:0]  SST_MAP_IDX_ADDR = 8'd127;
   localparam logic [15:0] M2_TIMEOUT       = 16'hFFFF;

   typedef struct packed {
      logic       act;
      logic [7:0] addr;
      logic       we_reg;
      logic [7:0] dato;
   } sst_bus_t;

endpackage

// File: rtl/sst_m2_sync.sv
// sst_m2_sync: synchronizes the asynchronous CPU M2 into clk and produces
// one-clk rise/fall pulses of the synchronized level.
//   clk, rst  : system clock, asynchronous active-high reset
//   m2_async  : raw CPU M2
//   m2_rise   : one-clk pulse on a synchronized 0->1 transition
//   m2_fall   : one-clk pulse on a synchronized 1->0 transition
// SYNC_STG must be at least 2. A raw edge shows up as a pulse SYNC_STG clk
// edges after it is first sampled.
module sst_m2_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic m2_async,
   output logic m2_rise,
   output logic m2_fall
);

   logic [SYNC_STG-1:0] sync_q;
   logic                prev_q;
   logic                m2_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], m2_async};
         prev_q <= sync_q[SYNC_STG-1];
      end
   end

   assign m2_s    = sync_q[SYNC_STG-1];
   assign m2_rise = m2_s & ~prev_q;
   assign m2_fall = ~m2_s & prev_q;

endmodule

// File: rtl/sst_seq.sv
// sst_seq: save-state sequencer, initiator end of the mapper SST bus.
//   Save walks SST addresses 0..REG_CNT-1 and copies each mapper byte (sst_di)
//   into the snapshot buffer; load copies the buffer back into the mapper with
//   m2-paced register writes.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   cpu_m2                   : CPU M2, asynchronous to clk
//   start_save, start_load   : one-clk start pulses (save wins if both)
//   busy, done, err          : status; err is sticky until the next start
//   sst_act/addr/we_reg/dato : SST master bundle to the mapper
//   sst_di                   : mapper readback for sst_addr
//   mem_addr/wr/rd/dout      : snapshot buffer request side
//   mem_din, mem_ack         : snapshot buffer response side
// Handshakes: mem_wr / mem_rd is a request that stays high, with mem_addr and
//   mem_dout stable, until the clk in which mem_ack is sampled high; mem_din is
//   valid in that clk and the request drops on the next clk. sst_we_reg is held
//   high, with sst_addr/sst_dato stable, across one complete falling edge of m2.
// Optional feature: define SST_MAP_CHECK_EN to verify the buffered mapper
//   index (address 127) against the live mapper before any load write.
// Debug: the FSM state is visible as the internal signal 'state'.
module sst_seq
   import sst_pkg::*;
#(
   parameter int REG_CNT  = 128,
   parameter int SYNC_STG = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_m2,
   input  logic       start_save,
   input  logic       start_load,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       sst_act,
   output logic [7:0] sst_addr,
   output logic       sst_we_reg,
   output logic [7:0] sst_dato,
   input  logic [7:0] sst_di,
   output logic [7:0] mem_addr,
   output logic       mem_wr,
   output logic       mem_rd,
   output logic [7:0] mem_dout,
   input  logic [7:0] mem_din,
   input  logic       mem_ack
);

   localparam logic [7:0]  LAST_ADDR = 8'(REG_CNT - 1);
   localparam logic [15:0] FRESH_CNT = 16'(SYNC_STG);

   sst_state_t  state, state_d;
   sst_bus_t    bus;
   logic        op_load;
   logic [7:0]  addr_q, dato_q, dout_q;
   logic [15:0] timer_q;
   logic        err_q, done_q;
   logic        m2_rise, m2_fall;
   logic        fresh_fall, tmo_hit, fail;

   sst_m2_sync #(.SYNC_STG(SYNC_STG)) u_m2_sync (
      .clk      (clk),
      .rst      (rst),
      .m2_async (cpu_m2),
      .m2_rise  (m2_rise),
      .m2_fall  (m2_fall)
   );

   // timer_q counts clks since entering the current state. A fall pulse seen
   // in the first SYNC_STG clks of a state comes from a raw edge that happened
   // before act/we_reg changed, so the mapper never saw it with the new bus
   // value; only later falls count.
   assign fresh_fall = m2_fall && (timer_q >= FRESH_CNT);
   assign tmo_hit    = (timer_q == (M2_TIMEOUT - 16'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      fail    = 1'b0;
      case (state)
         ST_IDLE:   if (start_save || start_load) state_d = ST_ARM;
         ST_ARM: begin
            if (fresh_fall) begin
               if (!op_load) state_d = ST_S_RD;
               else begin
`ifdef SST_MAP_CHECK_EN
                  state_d = ST_C_RD;
`else
                  state_d = ST_L_RD;
`endif
               end
            end else if (tmo_hit) begin
               fail    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         // Two clks with sst_addr held before sampling sst_di.
         ST_S_RD:   if (timer_q[0]) state_d = ST_S_WR;
         ST_S_WR:   if (mem_ack) state_d = ST_NEXT;
         ST_L_RD:   if (mem_ack) state_d = ST_L_WR;
         ST_L_WR: begin
            if (fresh_fall) state_d = ST_L_HOLD;
            else if (tmo_hit) begin
               fail    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         // M2 stuck low after the write edge would otherwise hang here.
         ST_L_HOLD: begin
            if (m2_rise) state_d = ST_NEXT;
            else if (tmo_hit) begin
               fail    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_NEXT: begin
            if (addr_q == LAST_ADDR) state_d = ST_FIN;
            else                     state_d = op_load ? ST_L_RD : ST_S_RD;
         end
         ST_FIN: begin
            if (fresh_fall) state_d = ST_IDLE;
            else if (tmo_hit) begin
               fail    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_C_RD:   if (mem_ack) state_d = ST_C_CMP;
         ST_C_CMP: begin
            if (timer_q[0]) begin
               if (sst_di != dato_q) begin
                  fail    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_L_RD;
               end
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_load <= 1'b0;
         addr_q  <= 8'd0;
         dato_q  <= 8'd0;
         dout_q  <= 8'd0;
         timer_q <= 16'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         timer_q <= (state_d != state) ? 16'd0 : timer_q + 16'd1;
         done_q  <= (state != ST_IDLE) && (state_d == ST_IDLE);
         if (fail) err_q <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start_save || start_load) begin
                  op_load <= !start_save;
                  addr_q  <= 8'd0;
                  err_q   <= 1'b0;
               end
            end
            ST_ARM: begin
`ifdef SST_MAP_CHECK_EN
               if (fresh_fall && op_load) addr_q <= SST_MAP_IDX_ADDR;
`endif
            end
            ST_S_RD:  if (timer_q[0]) dout_q <= sst_di;
            ST_L_RD,
            ST_C_RD:  if (mem_ack) dato_q <= mem_din;
            ST_C_CMP: if (timer_q[0] && !fail) addr_q <= 8'd0;
            ST_NEXT:  if (addr_q != LAST_ADDR) addr_q <= addr_q + 8'd1;
            default:  ;
         endcase
      end
   end

   // Strobes decode straight from the state register so an async reset drops
   // them immediately.
   always_comb begin
      bus.act    = (state != ST_IDLE);
      bus.addr   = addr_q;
      bus.we_reg = (state == ST_L_WR) || (state == ST_L_HOLD);
      bus.dato   = dato_q;
   end

   assign sst_act    = bus.act;
   assign sst_addr   = bus.addr;
   assign sst_we_reg = bus.we_reg;
   assign sst_dato   = bus.dato;
   assign busy       = (state != ST_IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign mem_addr   = addr_q;
   assign mem_wr     = (state == ST_S_WR);
   assign mem_rd     = (state == ST_L_RD) || (state == ST_C_RD);
   assign mem_dout   = dout_q;

endmodule

// File: tb/tb_sst_seq.sv
// tb_sst_seq: bench for sst_seq. Models the mapper (register file sampled on
// the falling edge of M2 while act and we_reg are high) and the snapshot
// buffer (random ack latency), and checks save/load traffic against an
// expected queue built from those models.
module tb_sst_seq;

   localparam int REG_CNT  = 128;
   localparam int SYNC_STG = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_m2;
   logic       start_save = 1'b0;
   logic       start_load = 1'b0;
   logic       busy, done, err;
   logic       sst_act, sst_we_reg;
   logic [7:0] sst_addr, sst_dato, sst_di;
   logic [7:0] mem_addr, mem_dout, mem_din;
   logic       mem_wr, mem_rd, mem_ack;

   logic [7:0]  map_regs[256];
   logic [7:0]  mem_buf[256];
   logic [7:0]  snap[256];
   logic [15:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cur_op = 0;       // 0 none, 1 save, 2 load
   int m2_half = 4;
   bit m2_run = 1'b1;
   int mem_lat = 3;
   bit tmo_test = 1'b0;
   int done_cnt = 0, we_pulses = 0, map_writes = 0, mem_writes = 0;
   logic m2_prev = 1'b0, we_prev = 1'b0, we_has_fall = 1'b0;

   assign sst_di = map_regs[sst_addr];

   always #5 clk = ~clk;

   sst_seq #(.REG_CNT(REG_CNT), .SYNC_STG(SYNC_STG)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_m2     (cpu_m2),
      .start_save (start_save),
      .start_load (start_load),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sst_act    (sst_act),
      .sst_addr   (sst_addr),
      .sst_we_reg (sst_we_reg),
      .sst_dato   (sst_dato),
      .sst_di     (sst_di),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_rd     (mem_rd),
      .mem_dout   (mem_dout),
      .mem_din    (mem_din),
      .mem_ack    (mem_ack)
   );

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // M2 generator, toggles 2 time units after posedge clk.
   initial begin
      cpu_m2 = 1'b0;
      forever begin
         repeat (m2_half) @(posedge clk);
         #2;
         if (m2_run) cpu_m2 = ~cpu_m2;
         else        cpu_m2 = 1'b0;
      end
   end

   // Snapshot buffer: ack after mem_lat clks, one clk wide.
   initial begin
      mem_ack = 1'b0;
      mem_din = 8'd0;
      forever begin
         @(posedge clk); #1;
         if (mem_ack) mem_ack = 1'b0;
         else if (!rst && (mem_wr || mem_rd)) begin
            repeat (mem_lat - 1) begin @(posedge clk); #1; end
            if (!rst && (mem_wr || mem_rd)) begin
               mem_ack = 1'b1;
               if (mem_wr) mem_buf[mem_addr] = mem_dout;
               else        mem_din = mem_buf[mem_addr];
            end
         end
      end
   end

   // Compare process: buffer writes, mapper writes, we_reg framing.
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst) begin
         m2_prev = cpu_m2;
         we_prev = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (cur_op == 1) chk("save_no_we", sst_we_reg, 1'b0);
         if (mem_wr && mem_ack) begin
            mem_writes++;
            if (cur_op == 1 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("mem_wr", {mem_addr, mem_dout}, e);
            end else begin
               n_checks++; n_errors++;
               $display("FAIL mem_wr_extra actual addr=%0d data=%0h required none", mem_addr, mem_dout);
            end
         end
         if (sst_we_reg && !we_prev) we_has_fall = 1'b0;
         if (m2_prev && !cpu_m2 && sst_act && sst_we_reg) begin
            map_writes++;
            we_has_fall = 1'b1;
            if (cur_op == 2 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("map_wr", {sst_addr, sst_dato}, e);
            end else begin
               n_checks++; n_errors++;
               $display("FAIL map_wr_extra actual addr=%0d data=%0h required none", sst_addr, sst_dato);
            end
            map_regs[sst_addr] = sst_dato;
         end
         if (!sst_we_reg && we_prev) begin
            we_pulses++;
            if (!tmo_test) chk("we_span_fall", we_has_fall, 1'b1);
         end
         m2_prev = cpu_m2;
         we_prev = sst_we_reg;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input bit s, input bit l);
      @(negedge clk);
      start_save = s;
      start_load = l;
      @(negedge clk);
      start_save = 1'b0;
      start_load = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      int n = 0;
      bit seen = 1'b0;
      while (n < max && !seen) begin
         @(negedge clk);
         n++;
         if (done) seen = 1'b1;
      end
      chk({name, "_done_seen"}, seen, 1'b1);
   endtask

   task automatic prep_save();
      exp_q.delete();
      for (int a = 0; a < REG_CNT; a++) exp_q.push_back({8'(a), map_regs[a]});
      cur_op = 1;
   endtask

   task automatic prep_load();
      exp_q.delete();
      for (int a = 0; a < REG_CNT; a++) exp_q.push_back({8'(a), mem_buf[a]});
      cur_op = 2;
   endtask

   initial begin
      int w0, d0, m0, p0, n, mism;
      for (int a = 0; a < 256; a++) begin map_regs[a] = 8'd0; mem_buf[a] = 8'd0; end

      // Reset state
      cycles(3);
      chk("rst_ctrl", {busy, done, err, sst_act, sst_we_reg, mem_wr, mem_rd}, 7'd0);
      chk("rst_data", {sst_addr, sst_dato, mem_addr, mem_dout}, 32'd0);
      rst = 1'b0;
      cycles(5);
      chk("idle_ctrl", {busy, done, err, sst_act, sst_we_reg, mem_wr, mem_rd}, 7'd0);

      // A: save, di = addr ^ 5A, ack latency 3
      m2_half = 4; mem_lat = 3;
      for (int a = 0; a < 256; a++) map_regs[a] = 8'(a) ^ 8'h5A;
      prep_save();
      w0 = mem_writes; d0 = done_cnt;
      pulse(1'b1, 1'b0);
      chk("A_busy", busy, 1'b1);
      chk("A_act", sst_act, 1'b1);
      wait_done("A", 5000);
      cycles(10);
      chk("A_writes", mem_writes - w0, 128);
      chk("A_q_empty", exp_q.size(), 0);
      chk("A_one_done", done_cnt - d0, 1);
      chk("A_err", err, 1'b0);
      chk("A_act_off", {sst_act, busy}, 2'b00);
      chk("A_buf0", mem_buf[0], 8'h5A);
      chk("A_buf127", mem_buf[127], 8'h25);
      cur_op = 0;

      // B: load, buffer = addr+1, m2 period 36
      for (int a = 0; a < 256; a++) begin mem_buf[a] = 8'(a + 1); map_regs[a] = 8'hEE; end
      map_regs[127] = mem_buf[127];
      m2_half = 18; mem_lat = $urandom_range(1, 4);
      prep_load();
      m0 = map_writes; p0 = we_pulses; d0 = done_cnt;
      pulse(1'b0, 1'b1);
      wait_done("B", 20000);
      cycles(5);
      chk("B_reg32", map_regs[32], 8'h21);
      chk("B_reg33", map_regs[33], 8'h22);
      chk("B_map_writes", map_writes - m0, 128);
      chk("B_we_pulses", we_pulses - p0, 128);
      chk("B_q_empty", exp_q.size(), 0);
      chk("B_one_done", done_cnt - d0, 1);
      chk("B_err", err, 1'b0);
      cur_op = 0;

      // C: save and load in the same clk, extra starts while busy
      for (int a = 0; a < 256; a++) map_regs[a] = 8'($urandom);
      m2_half = 3; mem_lat = $urandom_range(1, 4);
      prep_save();
      w0 = mem_writes; m0 = map_writes; d0 = done_cnt;
      pulse(1'b1, 1'b1);
      cycles(3);
      pulse(1'b0, 1'b1);
      cycles(5);
      pulse(1'b1, 1'b0);
      wait_done("C", 5000);
      cycles(20);
      chk("C_writes", mem_writes - w0, 128);
      chk("C_no_map_writes", map_writes - m0, 0);
      chk("C_one_done", done_cnt - d0, 1);
      chk("C_q_empty", exp_q.size(), 0);
      chk("C_busy", busy, 1'b0);
      cur_op = 0;

      // Random save/restore round trips
      for (int it = 0; it < 2; it++) begin
         m2_half = $urandom_range(3, 5);
         mem_lat = $urandom_range(1, 4);
         for (int a = 0; a < 256; a++) begin map_regs[a] = 8'($urandom); snap[a] = map_regs[a]; end
         prep_save();
         pulse(1'b1, 1'b0);
         wait_done("RT_save", 5000);
         cycles(5);
         chk("RT_save_q", exp_q.size(), 0);
         for (int a = 0; a < 256; a++) map_regs[a] = 8'($urandom);
         map_regs[127] = snap[127];
         prep_load();
         pulse(1'b0, 1'b1);
         wait_done("RT_load", 10000);
         cycles(5);
         mism = 0;
         for (int a = 0; a < REG_CNT; a++) if (map_regs[a] !== snap[a]) mism++;
         chk("RT_restore_mismatches", mism, 0);
         chk("RT_err", err, 1'b0);
         cur_op = 0;
      end

      // D: m2 stops during load -> timeout; next save clears err
      m2_half = 5; mem_lat = 2;
      map_regs[127] = mem_buf[127];
      prep_load();
      tmo_test = 1'b1;
      d0 = done_cnt;
      pulse(1'b0, 1'b1);
      n = 0;
      while (n < 2000 && !mem_rd) begin @(negedge clk); n++; end
      chk("D_mem_rd_seen", mem_rd, 1'b1);
      m2_run = 1'b0;
      wait_done("D", 70000);
      cycles(2);
      chk("D_err", err, 1'b1);
      chk("D_act", sst_act, 1'b0);
      chk("D_we", sst_we_reg, 1'b0);
      chk("D_busy", busy, 1'b0);
      chk("D_one_done", done_cnt - d0, 1);
      exp_q.delete();
      cur_op = 0;
      tmo_test = 1'b0;
      m2_run = 1'b1;
      prep_save();
      pulse(1'b1, 1'b0);
      cycles(2);
      chk("D_err_cleared", err, 1'b0);
      wait_done("D_save", 5000);
      cycles(5);
      chk("D_save_err", err, 1'b0);
      chk("D_save_q", exp_q.size(), 0);
      cur_op = 0;

      // E: reset in the middle of a write hold
      m2_half = 6; mem_lat = 1;
      map_regs[127] = mem_buf[127];
      prep_load();
      pulse(1'b0, 1'b1);
      n = 0;
      while (n < 3000 && !sst_we_reg) begin @(negedge clk); n++; end
      while (n < 3000 && !cpu_m2) begin @(negedge clk); n++; end
      while (n < 3000 && cpu_m2) begin @(negedge clk); n++; end
      chk("E_reached_fall", {sst_we_reg, cpu_m2}, 2'b10);
      cycles(4);
      chk("E_pre_we", sst_we_reg, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("E_act", sst_act, 1'b0);
      chk("E_we", sst_we_reg, 1'b0);
      chk("E_mem_rd", mem_rd, 1'b0);
      chk("E_busy", busy, 1'b0);
      chk("E_addr", sst_addr, 8'd0);
      exp_q.delete();
      cur_op = 0;
      cycles(2);
      rst = 1'b0;
      cycles(5);
      chk("E_idle", {busy, done, err}, 3'b000);

`ifdef SST_MAP_CHECK_EN
      // F: mapper index check
      m2_half = 4; mem_lat = 2;
      mem_buf[127] = 8'h04;
      map_regs[127] = 8'h05;
      prep_load();
      p0 = we_pulses; m0 = map_writes;
      pulse(1'b0, 1'b1);
      wait_done("F_bad", 3000);
      cycles(5);
      chk("F_err", err, 1'b1);
      chk("F_no_we", we_pulses - p0, 0);
      chk("F_no_writes", map_writes - m0, 0);
      exp_q.delete();
      mem_buf[127] = 8'h05;
      prep_load();
      m0 = map_writes;
      pulse(1'b0, 1'b1);
      wait_done("F_good", 10000);
      cycles(5);
      chk("F_good_err", err, 1'b0);
      chk("F_good_writes", map_writes - m0, 128);
      chk("F_good_reg127", map_regs[127], 8'h05);
      cur_op = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
